cdc_stable_capture: RTL and testbench

// - Sequences readout of a multi-bit word that arrives through the cdc delay-line synchronizer.
//   The bits of that word can settle on different cycles.
// - On request, watches the synchronized word until it has held one value for STABLE_CYCLES

---
 rtl/cdc_stable_capture.sv | 157 +++++++++++++++
 tb/tb_cdc_stable_capture.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdc_stable_capture.sv
// Captures a word from a delay-line synchronizer once it has held one value long enough.
// Optional forced-capture timeout is enabled with `define CDC_STABLE_CAPTURE_TIMEOUT_EN.
module cdc_stable_capture #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned STABLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  req_valid,
  output logic                  req_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_timeout,
  output logic                  busy
);

  localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_CYCLES);

  if (STABLE_CYCLES < 1 || STABLE_CYCLES > 255) begin : g_bad_stable
    $error("cdc_stable_capture: STABLE_CYCLES must be in 1..255");
  end
  if (TIMEOUT_CYCLES < STABLE_CYCLES) begin : g_bad_timeout
    $error("cdc_stable_capture: TIMEOUT_CYCLES must be >= STABLE_CYCLES");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    OUTPUT = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] prev_q, prev_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;
  logic                  stable_hit;

`ifdef CDC_STABLE_CAPTURE_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] tmr_q, tmr_d;
  logic          out_timeout_q, out_timeout_d;
`endif

  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    stable_hit  = 1'b0;
`ifdef CDC_STABLE_CAPTURE_TIMEOUT_EN
    tmr_d         = tmr_q;
    out_timeout_d = out_timeout_q;
`endif

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          prev_d  = in_data;
          cnt_d   = '0;
          state_d = SETTLE;
`ifdef CDC_STABLE_CAPTURE_TIMEOUT_EN
          tmr_d   = '0;
`endif
        end
      end

      SETTLE: begin
`ifdef CDC_STABLE_CAPTURE_TIMEOUT_EN
        tmr_d = tmr_q + 1'b1;
`endif
        if (in_data == prev_q) begin
          // Saturate so an oversized count can never wrap back into range.
          cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            stable_hit  = 1'b1;
            out_data_d  = prev_q;
            out_valid_d = 1'b1;
            state_d     = OUTPUT;
`ifdef CDC_STABLE_CAPTURE_TIMEOUT_EN
            out_timeout_d = 1'b0;
`endif
          end
        end else begin
          cnt_d  = '0;
          prev_d = in_data;
        end
`ifdef CDC_STABLE_CAPTURE_TIMEOUT_EN
        // A stable capture on the same edge takes priority over the forced one.
        if (!stable_hit && tmr_q == TMR_LAST) begin
          out_data_d    = in_data;
          out_valid_d   = 1'b1;
          out_timeout_d = 1'b1;
          state_d       = OUTPUT;
        end
`endif
      end

      OUTPUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q     <= IDLE;
      prev_q      <= '0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

`ifdef CDC_STABLE_CAPTURE_TIMEOUT_EN
  always_ff @(posedge aclk) begin
    if (areset) begin
      tmr_q         <= '0;
      out_timeout_q <= 1'b0;
    end else begin
      tmr_q         <= tmr_d;
      out_timeout_q <= out_timeout_d;
    end
  end

  assign out_timeout = out_timeout_q;
`else
  assign out_timeout = 1'b0;
`endif

  assign req_ready = (state_q == IDLE) && !areset;
  assign busy      = (state_q != IDLE);
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_cdc_stable_capture.sv
// Scoreboard bench for cdc_stable_capture: stimulus pushes modelled captures, a monitor pops them.
module tb_cdc_stable_capture;

  localparam int STABLE  = 4;
  localparam int TIMEOUT = 16;
  localparam int SEQ_LEN = 64;

  logic        aclk;
  logic        areset;
  logic [31:0] in_data;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_timeout;
  logic        busy;

  cdc_stable_capture #(
    .DATA_WIDTH    (32),
    .STABLE_CYCLES (STABLE),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .aclk       (aclk),
    .areset     (areset),
    .in_data    (in_data),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_timeout(out_timeout),
    .busy       (busy)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct {
    logic [31:0] data;
    bit          to;
    int          lat;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] seq[SEQ_LEN];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          txn_n = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: capture at the first edge whose sample ends a run of STABLE+1 equal samples
  // (all taken at or after the accept edge); otherwise forced at edge TIMEOUT when enabled.
  function automatic void model(output int e, output logic [31:0] v, output bit to);
    bit ok;
    e = -1; v = '0; to = 1'b0;
    for (int j = 1; j < SEQ_LEN; j++) begin
      ok = (j >= STABLE);
      if (ok)
        for (int m = j - STABLE; m < j; m++)
          if (seq[m] != seq[j]) ok = 1'b0;
      if (ok) begin
        e = j; v = seq[j]; to = 1'b0;
        return;
      end
`ifdef CDC_STABLE_CAPTURE_TIMEOUT_EN
      if (j == TIMEOUT) begin
        e = j; v = seq[j]; to = 1'b1;
        return;
      end
`endif
    end
  endfunction

  task automatic fill_const(input logic [31:0] v);
    for (int i = 0; i < SEQ_LEN; i++) seq[i] = v;
  endtask

  task automatic fill_random();
    logic [31:0] pool[3];
    int tail;
    for (int p = 0; p < 3; p++) pool[p] = $urandom;
    tail = $urandom_range(40, 5);
    for (int i = 0; i < SEQ_LEN; i++)
      seq[i] = (i < tail) ? pool[$urandom_range(2, 0)] : pool[0];
  endtask

  // Runs one request from acceptance until the DUT returns to IDLE.
  task automatic issue(input bit hold_req, input int bp, input bit rnd_ready, input bit expect_now);
    int e;
    logic [31:0] v;
    bit to;
    int n;
    int i;
    int bpc;
    model(e, v, to);
    if (expect_now) chk("reaccept_ready", {63'd0, req_ready}, 64'd1);
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge aclk);
      n++;
    end
    if (!req_ready) begin
      chk("accept_wait", {63'd0, req_ready}, 64'd1);
      return;
    end
    if (e >= 0) exp_q.push_back('{data: v, to: to, lat: e});
    req_valid = 1'b1;
    in_data   = seq[0];
    out_ready = rnd_ready ? 1'($urandom_range(1, 0)) : (bp > 0 ? 1'b0 : 1'b1);
    i = 1;
    bpc = 0;
    n = 0;
    forever begin
      @(negedge aclk);
      if (!busy) begin
        if (!hold_req) req_valid = 1'b0;
        break;
      end
      if (n > 300) begin
        chk("settle_bound", {63'd0, busy}, 64'd0);
        req_valid = 1'b0;
        break;
      end
      n++;
      in_data   = (i < SEQ_LEN) ? seq[i] : seq[SEQ_LEN-1];
      i++;
      req_valid = hold_req ? 1'b1 : 1'($urandom_range(1, 0));
      if (out_valid && bpc >= bp) begin
        out_ready = rnd_ready ? 1'($urandom_range(1, 0)) : 1'b1;
      end else begin
        if (out_valid) bpc++;
        out_ready = rnd_ready ? 1'($urandom_range(1, 0)) : (bp > 0 ? 1'b0 : 1'b1);
      end
    end
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  initial begin
    bit          prev_valid = 1'b0;
    bit          prev_busy = 1'b0;
    logic [31:0] prev_data = '0;
    bit          prev_to = 1'b0;
    int          accept_cyc = 0;
    exp_t        x;
    forever begin
      @(posedge aclk);
      cyc++;
      #1;
      if (areset) begin
        prev_valid = 1'b0;
        prev_busy  = 1'b0;
      end else begin
        if (!prev_busy && busy) accept_cyc = cyc;
        if (prev_valid) begin
          if (out_ready)
            chk("handshake_drop", {63'd0, out_valid}, 64'd0);
          else
            chk("output_hold", {30'd0, out_valid, out_data, out_timeout},
                {30'd0, 1'b1, prev_data, prev_to});
        end else if (out_valid) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_output", {63'd0, out_valid}, 64'd0);
          end else begin
            x = exp_q.pop_front();
            txn_n++;
            $display("txn %0d: data=%h timeout=%0d latency=%0d (expected data=%h timeout=%0d latency=%0d)",
                     txn_n, out_data, out_timeout, cyc - accept_cyc, x.data, x.to, x.lat);
            chk("out_data", {32'd0, out_data}, {32'd0, x.data});
            chk("out_timeout", {63'd0, out_timeout}, {63'd0, x.to});
            chk("latency", 64'(cyc - accept_cyc), 64'(x.lat));
          end
        end
        prev_valid = out_valid;
        prev_busy  = busy;
        prev_data  = out_data;
        prev_to    = out_timeout;
      end
    end
  end

  initial begin
    int ok_cnt;
    areset    = 1'b1;
    req_valid = 1'b1;
    in_data   = 32'h1234_5678;
    out_ready = 1'b1;

    // T1: reset with a pending request
    for (int c = 0; c < 3; c++) begin
      @(negedge aclk);
      chk("reset_state", {29'd0, req_ready, out_valid, busy, out_timeout, |out_data},
          64'd0);
    end
    areset    = 1'b0;
    req_valid = 1'b0;
    @(negedge aclk);
    chk("idle_ready", {63'd0, req_ready}, 64'd1);

    // T2: constant word
    fill_const(32'hA5A5_0001);
    issue(1'b0, 0, 1'b0, 1'b0);

    // T3: glitch on the fourth sample
    for (int i = 0; i < SEQ_LEN; i++) seq[i] = (i < 3) ? 32'hA5A5_0001 : 32'h0000_00FF;
    issue(1'b0, 0, 1'b0, 1'b0);

    // T4: backpressure, request held, immediate re-accept
    fill_const(32'hDEAD_BEEF);
    issue(1'b1, 10, 1'b0, 1'b0);
    fill_const(32'h0BAD_F00D);
    issue(1'b0, 0, 1'b0, 1'b1);

    // T5: toggling input
    for (int i = 0; i < SEQ_LEN; i++) seq[i] = i[0] ? 32'h5555_AAAA : 32'hAAAA_5555;
`ifdef CDC_STABLE_CAPTURE_TIMEOUT_EN
    issue(1'b0, 0, 1'b0, 1'b0);
`else
    while (!req_ready) @(negedge aclk);
    req_valid = 1'b1;
    in_data   = seq[0];
    ok_cnt = 0;
    for (int c = 1; c <= 120; c++) begin
      @(negedge aclk);
      req_valid = 1'b0;
      in_data   = seq[c % 2];
      if (busy && !out_valid) ok_cnt++;
    end
    chk("no_timeout_wait", 64'(ok_cnt), 64'd120);
    areset = 1'b1;
    repeat (2) @(negedge aclk);
    areset = 1'b0;
    chk("abort_idle", {62'd0, busy, out_valid}, 64'd0);
`endif

    // T6: reset two cycles after accept
    while (!req_ready) @(negedge aclk);
    req_valid = 1'b1;
    in_data   = 32'h7777_0000;
    @(negedge aclk);
    req_valid = 1'b0;
    chk("t6_busy", {63'd0, busy}, 64'd1);
    @(negedge aclk);
    areset = 1'b1;
    ok_cnt = 0;
    repeat (2) begin
      @(negedge aclk);
      if (!busy && !out_valid && !req_ready) ok_cnt++;
    end
    areset = 1'b0;
    chk("t6_reset_idle", 64'(ok_cnt), 64'd2);
    repeat (6) begin
      @(negedge aclk);
      if (out_valid) ok_cnt++;
    end
    chk("t6_no_output", 64'(ok_cnt), 64'd2);
    fill_const(32'hA5A5_0001);
    issue(1'b0, 0, 1'b0, 1'b0);

    // Random sequences with random backpressure and request noise
    for (int t = 0; t < 12; t++) begin
      fill_random();
      issue(1'b0, 0, 1'b1, 1'b0);
    end

    repeat (5) @(negedge aclk);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    chk("final_idle", {63'd0, busy}, 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
